// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and parity helper for the PISO serializer.
package piso_pkg;
  localparam int PISO_MAX_WIDTH = 64;
  typedef enum logic [1:0] {PISO_IDLE, PISO_SHIFT, PISO_PARITY} piso_state_e;
  function automatic logic piso_parity(input logic [PISO_MAX_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded, bit_en paced parallel-to-serial shifter.
// Define PISO_PARITY_EN to append a parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MSB_FIRST  = 0,
  parameter int IDLE_LEVEL = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  if (WIDTH < 2 || WIDTH > PISO_MAX_WIDTH || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("piso_serializer: WIDTH must be 2..64 and PARITY_ODD 0 or 1");
  end
  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d, valid_q, valid_d;
  logic             first_bit, next_bit, last_data, end_bit, load;
  assign first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign shifted   = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  assign next_bit  = (MSB_FIRST != 0) ? shifted[WIDTH-1] : shifted[0];
  assign last_data = state_q == PISO_SHIFT && cnt_q == LAST;
`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  // the parity bit, not the last data bit, closes the frame
  assign end_bit   = bit_en && state_q == PISO_PARITY;
  assign dout_last = state_q == PISO_PARITY;
`else
  assign end_bit   = bit_en && last_data;
  assign dout_last = last_data;
`endif
  assign din_ready  = state_q == PISO_IDLE || end_bit;
  assign load       = din_valid && din_ready;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = state_q != PISO_IDLE;
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (load) begin
      state_d = PISO_SHIFT;
      sreg_d  = din;
      cnt_d   = '0;
      dout_d  = first_bit;
      valid_d = 1'b1;
`ifdef PISO_PARITY_EN
      par_d   = piso_parity(PISO_MAX_WIDTH'(din), 1'(PARITY_ODD));
`endif
    end else if (end_bit) begin
      state_d = PISO_IDLE;
      dout_d  = 1'(IDLE_LEVEL);
      valid_d = 1'b0;
    end else if (state_q == PISO_SHIFT && bit_en) begin
      sreg_d = shifted;
      cnt_d  = cnt_q + CW'(1);
`ifdef PISO_PARITY_EN
      state_d = last_data ? PISO_PARITY : PISO_SHIFT;
      dout_d  = last_data ? par_q : next_bit;
`else
      dout_d  = next_bit;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PISO_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'(IDLE_LEVEL);
      valid_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: two serializers (LSB-first/idle 0/even, MSB-first/idle 1/odd)
// checked every cycle against a frame-index reference model plus literal frame patterns.
module tb_piso_serializer;
  localparam int W = 16;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
  localparam logic [FL-1:0] EXP_A1 = {1'b0, 16'hA5C3};
  localparam logic [FL-1:0] EXP_B1 = {1'b1, 16'hC3A5};
  localparam logic [FL-1:0] EXP_L1 = 17'h10000;
  localparam logic [2*FL-1:0] EXP_BB = {1'b0, 16'h0000, 1'b0, 16'hFFFF};
`else
  localparam int FL = W;
  localparam logic [FL-1:0] EXP_A1 = 16'hA5C3;
  localparam logic [FL-1:0] EXP_B1 = 16'hC3A5;
  localparam logic [FL-1:0] EXP_L1 = 16'h8000;
  localparam logic [2*FL-1:0] EXP_BB = {16'h0000, 16'hFFFF};
`endif
  logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, bit_en = 1'b0;
  logic [W-1:0] din = '0;
  logic rdy_a, dout_a, val_a, last_a, busy_a;
  logic rdy_b, dout_b, val_b, last_b, busy_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(0), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_a),
    .bit_en(bit_en), .dout(dout_a), .dout_valid(val_a), .dout_last(last_a), .busy(busy_a));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1), .PARITY_ODD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_b),
    .bit_en(bit_en), .dout(dout_b), .dout_valid(val_b), .dout_last(last_b), .busy(busy_b));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // reference: which word is in flight and which frame position is on the line
  logic m_active = 1'b0;
  int m_idx = 0;
  logic [W-1:0] m_word = '0;
  function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb, input bit odd);
    if (idx >= W) return (^w) ^ odd;
    return msb ? w[W-1-idx] : w[idx];
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_idx <= 0;
      m_word <= '0;
    end else if (din_valid && (!m_active || (m_idx == FL-1 && bit_en))) begin
      m_active <= 1'b1;
      m_idx <= 0;
      m_word <= din;
    end else if (m_active && bit_en) begin
      if (m_idx == FL-1) m_active <= 1'b0;
      m_idx <= m_idx + 1;
    end
  end
  always @(negedge clk) begin
    chk("a_dout", dout_a, m_active ? exp_bit(m_word, m_idx, 1'b0, 1'b0) : 1'b0);
    chk("b_dout", dout_b, m_active ? exp_bit(m_word, m_idx, 1'b1, 1'b1) : 1'b1);
    chk("a_valid", val_a, m_active);
    chk("b_valid", val_b, m_active);
    chk("a_last", last_a, m_active && m_idx == FL-1);
    chk("b_last", last_b, m_active && m_idx == FL-1);
    chk("a_busy", busy_a, m_active);
    chk("b_busy", busy_b, m_active);
    chk("a_ready", rdy_a, !m_active || (m_idx == FL-1 && bit_en));
    chk("b_ready", rdy_b, !m_active || (m_idx == FL-1 && bit_en));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [W-1:0] w, output logic [FL-1:0] ca, output logic [FL-1:0] cb,
                       output logic [FL-1:0] la);
    din = w;
    din_valid = 1'b1;
    bit_en = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      ca[i] = dout_a;
      cb[i] = dout_b;
      la[i] = last_a;
    end
    @(negedge clk);
    chk("idle_after_frame", {val_a, val_b, dout_a, dout_b}, 4'b0001);
    tick();
  endtask
  initial begin
    logic [FL-1:0] ca, cb, la;
    logic [2*FL-1:0] bb_d, bb_v, bb_r;
    int n;
    repeat (2) tick();
    chk("reset_outputs", {val_a, val_b, dout_a, dout_b, last_a, busy_a}, 6'b000100);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", {rdy_a, rdy_b}, 2'b11);
    frame(16'hA5C3, ca, cb, la);
    chk("lsb_frame_A5C3", ca, EXP_A1);
    chk("msb_frame_A5C3", cb, EXP_B1);
    chk("last_position", la, EXP_L1);
    frame(16'h8001, ca, cb, la);
    chk("msb_frame_8001", cb[W-1:0], 16'h8001);
    din = 16'hFFFF;
    din_valid = 1'b1;
    bit_en = 1'b1;
    tick();
    din = 16'h0000;
    for (int i = 0; i < 2*FL; i++) begin
      @(negedge clk);
      bb_d[i] = dout_a;
      bb_v[i] = val_a;
      bb_r[i] = rdy_a;
    end
    din_valid = 1'b0;
    chk("b2b_data", bb_d, EXP_BB);
    chk("b2b_valid", bb_v, (64'd1 << (2*FL)) - 64'd1);
    chk("b2b_ready", bb_r, (64'd1 << (FL-1)) | (64'd1 << (2*FL-1)));
    @(negedge clk);
    chk("b2b_idle", val_a, 1'b0);
    tick();
    din = 16'h0003;
    din_valid = 1'b1;
    bit_en = 1'b0;
    tick();
    n = 0;
    for (int c = 0; c < 4*FL + 4; c++) begin
      bit_en = (c % 4 == 3);
      din = W'($urandom);
      din_valid = (c < 40);
      @(negedge clk);
      if (val_a) n++;
      if (c == 0) chk("slow_bit0", dout_a, 1'b1);
      if (c == 7) chk("slow_bit1_held", dout_a, 1'b1);
      if (c == 8) chk("slow_bit2", dout_a, 1'b0);
      tick();
    end
    chk("slow_frame_cycles", n, 4*FL);
    din_valid = 1'b0;
    din = 16'h5A5A;
    din_valid = 1'b1;
    bit_en = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_frame", {val_a, val_b, dout_a, dout_b, busy_a}, 5'b00010);
    tick();
    rst_n = 1'b1;
    tick();
    frame(16'h0003, ca, cb, la);
    chk("clean_frame_after_reset", ca[W-1:0], 16'h0003);
`ifdef PISO_PARITY_EN
    frame(16'h0007, ca, cb, la);
    chk("parity_even_0007", ca[FL-1], 1'b1);
    chk("parity_odd_0007", cb[FL-1], 1'b0);
    chk("parity_last", la, EXP_L1);
`endif
    for (int c = 0; c < 600; c++) begin
      din = W'($urandom);
      din_valid = ($urandom_range(9) < 6);
      bit_en = ($urandom_range(3) != 0);
      rst_n = ($urandom_range(149) != 0);
      tick();
    end
    rst_n = 1'b1;
    din_valid = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
